// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one outstanding fetch at a time.
// A fetch walks REQ -> WAIT -> ISSUE. A retirement to a misaligned PC parks
// the unit in TRAP until reset.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        misaligned,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'b00,
    S_WAIT  = 2'b01,
    S_ISSUE = 2'b10,
    S_TRAP  = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] instret_r;
  logic        misaligned_r;
  logic        req_valid_r;
  logic        instr_valid_r;
  logic        capture_s;
  logic        retire_s;
  logic        trap_s;

  // Next-state decode plus the capture/retire/trap strobes for the datapath.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    retire_s  = 1'b0;
    trap_s    = 1'b0;
    case (state_r)
      S_REQ: begin
        if (imem_req_ready) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          capture_s = 1'b1;
          state_s   = S_ISSUE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          retire_s = 1'b1;
          if (pc_next[1:0] == 2'b00) begin
            state_s = S_REQ;
          end else begin
            trap_s  = 1'b1;
            state_s = S_TRAP;
          end
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_TRAP: begin
        state_s = S_TRAP;
      end
      default: begin
        // An illegal encoding is treated as a trap so the unit stops fetching.
        state_s = S_TRAP;
      end
    endcase
  end

  // State register; reset restarts fetching from the reset vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_REQ;
    end else begin
      state_r <= state_s;
    end
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_r   <= 1'b1;
      instr_valid_r <= 1'b0;
    end else begin
      req_valid_r   <= (state_s == S_REQ);
      instr_valid_r <= (state_s == S_ISSUE);
    end
  end

  // PC advances only on the retiring edge; a misaligned target is kept for inspection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_VECTOR;
    end else if (retire_s) begin
      pc_r <= pc_next;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Instruction word is captured only while waiting; stray responses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= NOP_INSTR;
    end else if (capture_s) begin
      instr_r <= imem_rsp_data;
    end else begin
      instr_r <= instr_r;
    end
  end

  // Retired-instruction counter, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= 32'h0000_0000;
    end else if (retire_s) begin
      instret_r <= instret_r + 32'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

  // Sticky misaligned flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_r <= 1'b0;
    end else if (trap_s) begin
      misaligned_r <= 1'b1;
    end else begin
      misaligned_r <= misaligned_r;
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = pc_r;
  assign instr_valid    = instr_valid_r;
  assign instr          = instr_r;
  assign pc             = pc_r;
  assign pc_plus_4      = pc_r + 32'd4;
  assign misaligned     = misaligned_r;
  assign instret        = instret_r;

endmodule
